// File: rtl/alu_cmd_sequencer_pkg.sv
// rtl/alu_cmd_sequencer_pkg.sv - shared defaults, FSM states and helpers for the ALU command sequencer
package alu_cmd_sequencer_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_OP_W   = 4;
    localparam int DEF_DEPTH  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Queued command packs {a, b, op}.
    function automatic int cmd_width(input int data_w, input int op_w);
        return 2 * data_w + op_w;
    endfunction

endpackage

// File: rtl/alu_cmd_sequencer_sync_fifo.sv
// rtl/alu_cmd_sequencer_sync_fifo.sv - single-clock FIFO holding queued ALU commands
module alu_cmd_sequencer_sync_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap on overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - issues queued commands to a combinational ALU and returns captured results
module alu_cmd_sequencer
    import alu_cmd_sequencer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int OP_W   = DEF_OP_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [DATA_W-1:0]          cmd_a,
    input  logic [DATA_W-1:0]          cmd_b,
    input  logic [OP_W-1:0]            cmd_op,
    output logic [DATA_W-1:0]          alu_a,
    output logic [DATA_W-1:0]          alu_b,
    output logic [OP_W-1:0]            alu_op,
    input  logic [DATA_W-1:0]          alu_r,
    input  logic                       alu_e,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_W-1:0]          rsp_r,
    output logic                       rsp_e,
    output logic [OP_W-1:0]            rsp_op,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       busy
);

    localparam int CMD_W = cmd_width(DATA_W, OP_W);

    state_t             state;
    state_t             next_state;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic [CMD_W-1:0]   head;

    assign cmd_ready = !fifo_full;
    assign push      = cmd_valid && cmd_ready;
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE) || (count != '0);

    alu_cmd_sequencer_sync_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({cmd_a, cmd_b, cmd_op}),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (count)
    );

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    next_state = SETTLE;
                end
            end
            SETTLE: next_state = RESP;
            RESP: begin
                // Accepting a response can issue the next command back-to-back.
                if (rsp_ready) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        next_state = SETTLE;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= '0;
            rsp_r  <= '0;
            rsp_e  <= 1'b0;
            rsp_op <= '0;
        end else begin
            state <= next_state;
            if (pop) begin
                {alu_a, alu_b, alu_op} <= head;
            end
            if (state == SETTLE) begin
                rsp_r  <= alu_r;
                rsp_e  <= alu_e;
                rsp_op <= alu_op;
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - directed and randomized checks of alu_cmd_sequencer against a command-queue model
module tb_alu_cmd_sequencer;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] op;
    } cmd_t;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [3:0] cmd_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_op;
    logic [7:0] alu_r;
    logic       alu_e;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_r;
    logic       rsp_e;
    logic [3:0] rsp_op;
    logic [2:0] count;
    logic       busy;

    int   vectors;
    int   miscompares;
    int   n_rsp;
    cmd_t exp_q[$];

    // Stand-in ALU: returns {e, r}.
    function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        int ia = int'(a);
        int ib = int'(b);
        int r;
        int e;
        e = 0;
        case (op)
            4'd0:  begin r = ia + ib; e = (r > 255) ? 1 : 0; end
            4'd1:  begin r = ia - ib; e = (ia < ib) ? 1 : 0; end
            4'd2:  r = ia & ib;
            4'd3:  r = ia | ib;
            4'd4:  r = ia ^ ib;
            4'd5:  r = 255 - ia;
            4'd6:  begin r = ia * 2; e = (ia >= 128) ? 1 : 0; end
            4'd7:  begin r = ia / 2; e = ia % 2; end
            4'd8:  begin r = ia + 1; e = (ia == 255) ? 1 : 0; end
            4'd9:  begin r = ia - 1; e = (ia == 0) ? 1 : 0; end
            4'd10: begin r = ia * ib; e = (r > 255) ? 1 : 0; end
            4'd11: begin r = 0; e = (ia == ib) ? 1 : 0; end
            4'd12: begin r = 0; e = (ia < ib) ? 1 : 0; end
            4'd13: r = ia;
            4'd14: r = ib;
            default: r = (ia % 16) * 16 + ia / 16;
        endcase
        r = ((r % 256) + 256) % 256;
        return {e[0], 8'(r)};
    endfunction

    assign {alu_e, alu_r} = alu_fn(alu_a, alu_b, alu_op);

    alu_cmd_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_op    (cmd_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_r     (alu_r),
        .alu_e     (alu_e),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_r     (rsp_r),
        .rsp_e     (rsp_e),
        .rsp_op    (rsp_op),
        .count     (count),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Records handshakes seen this cycle, scores any accepted response, then advances one edge.
    task automatic step();
        logic [8:0] ex;
        if (cmd_valid && cmd_ready) begin
            exp_q.push_back('{a: cmd_a, b: cmd_b, op: cmd_op});
        end
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("rsp_spurious", 32'(rsp_valid), 32'd0);
            end else begin
                ex = alu_fn(exp_q[0].a, exp_q[0].b, exp_q[0].op);
                check("rsp_op", 32'(rsp_op), 32'(exp_q[0].op));
                check("rsp_r", 32'(rsp_r), 32'(ex[7:0]));
                check("rsp_e", 32'(rsp_e), 32'(ex[8]));
                void'(exp_q.pop_front());
            end
            n_rsp++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int expect_n);
        int base = n_rsp;
        for (int c = 0; c < 200 && (exp_q.size() != 0 || busy); c++) begin
            step();
        end
        check("drain_rsp_count", 32'(n_rsp - base), 32'(expect_n));
        check("drain_idle", 32'(busy), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_count"}, 32'(count), 32'd0);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_alu"}, 32'({alu_a, alu_b, alu_op}), 32'd0);
        check({tag, "_rsp"}, 32'({rsp_r, rsp_e, rsp_op}), 32'd0);
    endtask

    initial begin
        int   base;
        int   sent;
        bit   saw_full;
        bit   hs;
        cmd_t c0;
        logic [8:0] ex;

        vectors     = 0;
        miscompares = 0;
        n_rsp       = 0;
        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_a       = '0;
        cmd_b       = '0;
        cmd_op      = '0;
        rsp_ready   = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst_n = 1'b1;
        step();
        step();
        check_idle_outputs("post_reset");

        // Single command latency
        base      = n_rsp;
        cmd_valid = 1'b1;
        cmd_a     = 8'd225;
        cmd_b     = 8'd200;
        cmd_op    = 4'd0;
        step();
        cmd_valid = 1'b0;
        check("single_count_t", 32'(count), 32'd1);
        check("single_rsp_valid_t", 32'(rsp_valid), 32'd0);
        step();
        check("single_alu_a", 32'(alu_a), 32'd225);
        check("single_alu_b", 32'(alu_b), 32'd200);
        check("single_alu_op", 32'(alu_op), 32'd0);
        check("single_rsp_valid_t1", 32'(rsp_valid), 32'd0);
        step();
        check("single_rsp_valid_t2", 32'(rsp_valid), 32'd1);
        check("single_rsp_r", 32'(rsp_r), 32'd169);
        check("single_rsp_e", 32'(rsp_e), 32'd1);
        step();
        check("single_rsp_done", 32'(rsp_valid), 32'd0);
        check("single_n_rsp", 32'(n_rsp - base), 32'd1);
        check("single_alu_hold", 32'(alu_a), 32'd225);

        // Opcode sweep with continuous offer
        base     = n_rsp;
        sent     = 0;
        saw_full = 1'b0;
        for (int cyc = 0; cyc < 300 && (sent < 16 || exp_q.size() != 0); cyc++) begin
            cmd_valid = (sent < 16);
            cmd_a     = 8'd225;
            cmd_b     = 8'd200;
            cmd_op    = 4'(sent);
            check("sweep_cmd_ready", 32'(cmd_ready), 32'(count != 3'd4));
            if (count == 3'd4 && !cmd_ready) saw_full = 1'b1;
            hs = cmd_valid && cmd_ready;
            step();
            if (hs) sent++;
        end
        cmd_valid = 1'b0;
        check("sweep_sent", 32'(sent), 32'd16);
        check("sweep_saw_full", 32'(saw_full), 32'd1);
        check("sweep_n_rsp", 32'(n_rsp - base), 32'd16);
        drain(0);

        // Backpressure: 5 commands offered while responses are stalled
        rsp_ready = 1'b0;
        sent      = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            cmd_valid = (sent < 5);
            if (sent < 5) begin
                cmd_a  = 8'($urandom);
                cmd_b  = 8'($urandom);
                cmd_op = 4'($urandom);
            end
            hs = cmd_valid && cmd_ready;
            if (rsp_valid) begin
                c0 = exp_q[0];
                ex = alu_fn(c0.a, c0.b, c0.op);
                check("bp_stable_r", 32'(rsp_r), 32'(ex[7:0]));
                check("bp_stable_e", 32'(rsp_e), 32'(ex[8]));
                check("bp_stable_op", 32'(rsp_op), 32'(c0.op));
            end
            step();
            while (hs && cmd_valid && sent < 5) begin
                sent++;
                hs = 1'b0;
            end
        end
        cmd_valid = 1'b0;
        check("bp_sent", 32'(sent), 32'd5);
        check("bp_count", 32'(count), 32'd4);
        check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        drain(5);

        // Simultaneous push and pop at count=2
        base      = n_rsp;
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cmd_valid = 1'b1;
            cmd_a     = 8'($urandom);
            cmd_b     = 8'($urandom);
            cmd_op    = 4'($urandom);
            step();
        end
        cmd_valid = 1'b0;
        step();
        step();
        check("simul_pre_count", 32'(count), 32'd2);
        check("simul_pre_rsp_valid", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_a     = 8'($urandom);
        cmd_b     = 8'($urandom);
        cmd_op    = 4'($urandom);
        step();
        cmd_valid = 1'b0;
        check("simul_count", 32'(count), 32'd2);
        drain(3);
        check("simul_total", 32'(n_rsp - base), 32'd4);

        // Reset while in SETTLE with 3 queued
        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        cmd_a     = 8'd7;
        cmd_b     = 8'd9;
        cmd_op    = 4'd1;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            cmd_valid = 1'b1;
            cmd_a     = 8'($urandom);
            cmd_b     = 8'($urandom);
            cmd_op    = 4'($urandom);
            step();
        end
        cmd_valid = 1'b0;
        check("rst_mid_full", 32'(count), 32'd4);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("rst_mid_pre_count", 32'(count), 32'd3);
        check("rst_mid_pre_rsp_valid", 32'(rsp_valid), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rst_mid");
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("rst_mid_no_stale", 32'(rsp_valid), 32'd0);
            step();
        end
        cmd_valid = 1'b1;
        cmd_a     = 8'd18;
        cmd_b     = 8'd52;
        cmd_op    = 4'd4;
        step();
        cmd_valid = 1'b0;
        drain(1);

        // Randomized traffic with random response backpressure
        base = n_rsp;
        sent = 0;
        for (int cyc = 0; cyc < 2000 && (sent < 40 || exp_q.size() != 0 || busy); cyc++) begin
            if (!cmd_valid && sent < 40 && $urandom_range(0, 3) != 0) begin
                cmd_valid = 1'b1;
                cmd_a     = 8'($urandom);
                cmd_b     = 8'($urandom);
                cmd_op    = 4'($urandom);
            end
            rsp_ready = ($urandom_range(0, 2) != 0);
            check("rand_cmd_ready", 32'(cmd_ready), 32'(count != 3'd4));
            hs = cmd_valid && cmd_ready;
            step();
            if (hs) begin
                sent++;
                cmd_valid = 1'b0;
            end
        end
        cmd_valid = 1'b0;
        check("rand_sent", 32'(sent), 32'd40);
        check("rand_n_rsp", 32'(n_rsp - base), 32'd40);
        check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
